// File: rtl/stage4_mem_if.sv
// EX->MEM->WB/ID handshake and data-SRAM response bundle for pipeline stage 4.
// The slave modport is the MEM stage; the master modport is its environment.
interface stage4_mem_if;
  logic        es_to_ms_valid;
  logic        ms_allow_in;
  logic [74:0] es_to_ms_bus;
  logic        ws_allow_in;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic [38:0] ms_to_ds_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        ms_timeout;

  modport slave (
    input  es_to_ms_valid, es_to_ms_bus, ws_allow_in, data_sram_data_ok, data_sram_rdata,
    output ms_allow_in, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_bus, ms_timeout
  );

  modport master (
    output es_to_ms_valid, es_to_ms_bus, ws_allow_in, data_sram_data_ok, data_sram_rdata,
    input  ms_allow_in, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_bus, ms_timeout
  );
endinterface

// File: rtl/stage4_mem.sv
// Pipeline stage 4 (MEM): latches EX results, waits for data-SRAM load data / store ack,
// aligns and extends load data. Optional MS_DATA_BYPASS_EN lets data_ok complete a load the same cycle.
module stage4_mem #(
  parameter int TIMEOUT_CYC = 0
) (
  input logic         clk,
  input logic         reset,
  stage4_mem_if.slave ms
);

  localparam int CW = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [73:0]   r_es_bus;
  logic [31:0]   r_rdata;
  logic [CW-1:0] r_cnt;
  logic          r_timeout;

  logic [31:0] w_pc, w_cal, w_ld_src, w_ld_val, w_final;
  logic        w_gr_we, w_rfm;
  logic [4:0]  w_dest;
  logic [2:0]  w_ld_op;
  logic [1:0]  w_addr;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_ms_valid, w_ready_go, w_allow_in, w_accept, w_data_hit, w_in_mem_req;
  logic [CW:0] w_cnt_inc;

  assign w_pc    = r_es_bus[31:0];
  assign w_gr_we = r_es_bus[32];
  assign w_rfm   = r_es_bus[33];
  assign w_dest  = r_es_bus[38:34];
  assign w_cal   = r_es_bus[70:39];
  assign w_ld_op = r_es_bus[73:71];
  assign w_addr  = w_cal[1:0];

  assign w_in_mem_req = ms.es_to_ms_bus[74];
  assign w_ms_valid   = (r_state != S_EMPTY);
  // data_ok only counts while a request is outstanding
  assign w_data_hit   = (r_state == S_WAIT) & ms.data_sram_data_ok;

`ifdef MS_DATA_BYPASS_EN
  assign w_ready_go = (r_state == S_DONE) | w_data_hit;
  assign w_ld_src   = (r_state == S_WAIT) ? ms.data_sram_rdata : r_rdata;
`else
  assign w_ready_go = (r_state == S_DONE);
  assign w_ld_src   = r_rdata;
`endif

  assign w_allow_in = !w_ms_valid | (w_ready_go & ms.ws_allow_in);
  assign w_accept   = ms.es_to_ms_valid & w_allow_in;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_EMPTY;
    else       r_state <= w_state_nxt;
  end

  // Handing off to WB (allow_in) takes priority; otherwise a WAIT response parks in DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY, S_WAIT, S_DONE: begin
        if (w_allow_in)
          w_state_nxt = ms.es_to_ms_valid ? (w_in_mem_req ? S_WAIT : S_DONE) : S_EMPTY;
        else if (w_data_hit)
          w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)         r_es_bus <= '0;
    else if (w_accept) r_es_bus <= ms.es_to_ms_bus[73:0];
  end

  always_ff @(posedge clk) begin
    if (reset)           r_rdata <= '0;
    else if (w_data_hit) r_rdata <= ms.data_sram_rdata;
  end

  // Load alignment: byte lane from addr[1:0], half lane from addr[1] only.
  always_comb begin
    w_byte = w_ld_src[7:0];
    case (w_addr)
      2'd1:    w_byte = w_ld_src[15:8];
      2'd2:    w_byte = w_ld_src[23:16];
      2'd3:    w_byte = w_ld_src[31:24];
      default: w_byte = w_ld_src[7:0];
    endcase
    w_half = w_addr[1] ? w_ld_src[31:16] : w_ld_src[15:0];
    case (w_ld_op)
      3'b001:  w_ld_val = {{24{w_byte[7]}}, w_byte};
      3'b010:  w_ld_val = {{16{w_half[15]}}, w_half};
      3'b011:  w_ld_val = {24'd0, w_byte};
      3'b100:  w_ld_val = {16'd0, w_half};
      default: w_ld_val = w_ld_src;
    endcase
  end

  assign w_final = w_rfm ? w_ld_val : w_cal;

  // Counter holds the number of completed WAIT cycles; timeout latches the edge it reaches TIMEOUT_CYC.
  assign w_cnt_inc = {1'b0, r_cnt} + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_accept && w_in_mem_req)
        r_cnt <= '0;
      else if ((r_state == S_WAIT) && !(&r_cnt))
        r_cnt <= r_cnt + 1'b1;
      if ((TIMEOUT_CYC != 0) && (r_state == S_WAIT) && (w_cnt_inc == (CW+1)'(TIMEOUT_CYC)))
        r_timeout <= 1'b1;
    end
  end

  assign ms.ms_allow_in    = w_allow_in;
  assign ms.ms_to_ws_valid = w_ms_valid & w_ready_go;
  assign ms.ms_to_ws_bus   = {w_gr_we, w_dest, w_final, w_pc};
  assign ms.ms_to_ds_bus   = {w_ms_valid & w_rfm & !w_ready_go,
                              w_ms_valid & w_gr_we & (w_dest != 5'd0),
                              w_dest, w_final};
  assign ms.ms_timeout     = r_timeout;

endmodule
